// File: rtl/fetch_port_pkg.sv
// fetch_port_pkg: shared widths, types and window depth for the instruction fetch port.
// Configuration macro: FETCH_PREFETCH_EN selects a three-slot window with speculative
// prefetch of the word after the argument; undefined gives a two-slot window.
package fetch_port_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned WADDR_W = 15;

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned NSLOT = 3;
`else
  localparam int unsigned NSLOT = 2;
`endif

  // Slot index width covers both window depths.
  localparam int unsigned IDX_W = 2;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [WADDR_W-1:0] waddr_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Word-address distance, wrapping mod 2^WADDR_W.
  function automatic waddr_t waddr_dist(input waddr_t a, input waddr_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/fetch_window.sv
// fetch_window: slot/valid registers of the instruction window.
// Aligns the registered window to the current word address every cycle (keep, shift
// down, or flush), applies at most one slot write, and reports the lowest slot still
// empty after that write. The aligned view is what the outputs show and what commits.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   p                current word address (pc[15:1])
//   wr_en/idx/data   slot write from an accepted memory response
//   base             aligned base (word address of slot 0)
//   valid            aligned valid bits
//   opc, arg, hold   aligned slot 0 / slot 1 words and not-ready flag
//   miss, miss_idx   an empty slot remains after the write, and the lowest one
// Depth follows FETCH_PREFETCH_EN through fetch_port_pkg.
module fetch_window
  import fetch_port_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  waddr_t           p,
  input  logic             wr_en,
  input  idx_t             wr_idx,
  input  word_t            wr_data,
  output waddr_t           base,
  output logic [NSLOT-1:0] valid,
  output word_t            opc,
  output word_t            arg,
  output logic             hold,
  output logic             miss,
  output idx_t             miss_idx
);

  localparam int N = int'(NSLOT);

  waddr_t           base_q;
  logic [NSLOT-1:0] v_q, v_a, v_d;
  word_t            w_q [NSLOT];
  word_t            w_a [NSLOT];
  word_t            w_d [NSLOT];
  waddr_t           d;

  // Alignment: after any shift or flush, slot 0 always sits at p.
  always_comb begin
    d = waddr_dist(p, base_q);
    v_a = '0;
    for (int i = 0; i < N; i++) w_a[i] = '0;
    for (int s = 0; s < N; s++) begin
      if (d == waddr_t'(s)) begin
        for (int i = 0; i + s < N; i++) begin
          v_a[i] = v_q[i+s];
          w_a[i] = w_q[i+s];
        end
      end
    end
  end

  always_comb begin
    v_d = v_a;
    for (int i = 0; i < N; i++) begin
      w_d[i] = w_a[i];
      if (wr_en && wr_idx == idx_t'(i)) begin
        v_d[i] = 1'b1;
        w_d[i] = wr_data;
      end
    end
  end

  // Lowest empty slot, counting the write landing this cycle as filled.
  always_comb begin
    miss     = 1'b0;
    miss_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!v_d[i]) begin
        miss     = 1'b1;
        miss_idx = idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      v_q    <= '0;
      for (int i = 0; i < N; i++) w_q[i] <= '0;
    end else begin
      base_q <= p;
      v_q    <= v_d;
      for (int i = 0; i < N; i++) w_q[i] <= w_d[i];
    end
  end

  assign base  = p;
  assign valid = v_a;
  assign opc   = w_a[0];
  assign arg   = w_a[1];
  assign hold  = ~(v_a[0] & v_a[1]);

endmodule

// File: rtl/fetch_port.sv
// fetch_port: instruction-word fetch port between a 16-bit memory bus and the fetch unit.
// Presents the words at PC and PC+2, holds the fetch unit until both are present, and
// refills the window with a single-outstanding req/ack read.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   pc                   byte PC (bit 0 ignored)
//   mem_req, mem_addr    registered read request and word address
//   mem_ack, mem_rdata   request accepted, data valid in the same cycle
//   fetch_opc, fetch_arg words at pc and pc+2, meaningful when hold=0
//   hold                 window not ready
// Configuration macro: FETCH_PREFETCH_EN (three-slot window with prefetch).
module fetch_port
  import fetch_port_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  output logic              mem_req,
  output logic [14:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       fetch_opc,
  output logic [15:0]       fetch_arg,
  output logic              hold
);

  localparam int N = int'(NSLOT);

  waddr_t           p, base_a, j;
  logic [NSLOT-1:0] v_a;
  logic             wr_en, miss;
  idx_t             wr_idx, miss_idx;
  logic             req_q, req_d;
  waddr_t           addr_q, addr_d;
  logic             unused_pc0;

  assign p          = pc[15:1];
  assign unused_pc0 = pc[0];

  // Responses are filtered against the aligned window: stale or duplicate data is dropped.
  always_comb begin
    j      = waddr_dist(addr_q, base_a);
    wr_en  = 1'b0;
    wr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req_q && mem_ack && j == waddr_t'(i) && !v_a[i]) begin
        wr_en  = 1'b1;
        wr_idx = idx_t'(i);
      end
    end
  end

  // A new request may go out when idle or on the ack edge (back-to-back).
  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    if (!req_q || mem_ack) begin
      req_d = miss;
      if (miss) addr_d = base_a + waddr_t'(miss_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
    end
  end

  fetch_window u_window (
    .clk      (clk),
    .rst      (rst),
    .p        (p),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (mem_rdata),
    .base     (base_a),
    .valid    (v_a),
    .opc      (fetch_opc),
    .arg      (fetch_arg),
    .hold     (hold),
    .miss     (miss),
    .miss_idx (miss_idx)
  );

  assign mem_req  = req_q;
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_fetch_port.sv
// tb_fetch_port: directed bench for fetch_port with a wait-state memory model returning
// 0xA000 + word address. Expectations for the prefetch build follow FETCH_PREFETCH_EN.
module tb_fetch_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] fetch_opc, fetch_arg;
  logic        hold;

  int unsigned waits = 0;
  int unsigned cnt = 0;
  logic        force_ack = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  fetch_port dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .fetch_opc (fetch_opc),
    .fetch_arg (fetch_arg),
    .hold      (hold)
  );

  always #5 clk = ~clk;

  // Memory: acks once the request has been up for `waits` cycles.
  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign mem_ack   = (mem_req && cnt >= waits) || force_ack;
  assign mem_rdata = 16'hA000 + {1'b0, mem_addr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 0 right after reset, with pc applied.
  task automatic do_reset(input logic [15:0] new_pc, input int unsigned w);
    waits     = w;
    force_ack = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
    pc  = new_pc;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Cold miss, zero-wait, pc=0
    do_reset(16'h0000, 0);
    check("rst_hold", 32'(hold), 32'd1);
    check("rst_opc", 32'(fetch_opc), 32'h0);
    check("rst_arg", 32'(fetch_arg), 32'h0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    step();
    check("cold_c1_hold", 32'(hold), 32'd1);
    check("cold_c1_req", 32'(mem_req), 32'd1);
    check("cold_c1_addr", 32'(mem_addr), 32'h0);
    step();
    check("cold_c2_hold", 32'(hold), 32'd1);
    check("cold_c2_addr", 32'(mem_addr), 32'h1);
    step();
    check("cold_c3_hold", 32'(hold), 32'd0);
    check("cold_c3_opc", 32'(fetch_opc), 32'hA000);
    check("cold_c3_arg", 32'(fetch_arg), 32'hA001);

    // Steady at pc=0x10, then one-word step to 0x12
    do_reset(16'h0010, 0);
    repeat (6) step();
    check("steady_hold", 32'(hold), 32'd0);
    check("steady_opc", 32'(fetch_opc), 32'hA008);
    pc = 16'h0012;
    #1;
`ifdef FETCH_PREFETCH_EN
    check("step_hold0", 32'(hold), 32'd0);
    check("step_opc", 32'(fetch_opc), 32'hA009);
    check("step_arg", 32'(fetch_arg), 32'hA00A);
`else
    check("step_hold0", 32'(hold), 32'd1);
    step();
    check("step_hold1", 32'(hold), 32'd1);
    check("step_addr", 32'(mem_addr), 32'h000A);
    step();
    check("step_hold2", 32'(hold), 32'd0);
    check("step_opc", 32'(fetch_opc), 32'hA009);
    check("step_arg", 32'(fetch_arg), 32'hA00A);
`endif

    // Jump while the request for word 9 waits 3 cycles
    do_reset(16'h0010, 3);
    repeat (5) step();
    check("jump_c5_addr", 32'(mem_addr), 32'h0009);
    pc = 16'h0400;
    #1;
    check("jump_c5_hold", 32'(hold), 32'd1);
    step();
    check("jump_c6_addr", 32'(mem_addr), 32'h0009);
    step();
    check("jump_c7_addr", 32'(mem_addr), 32'h0009);
    step();
    check("jump_c8_addr", 32'(mem_addr), 32'h0009);
    check("jump_c8_ack", 32'(mem_ack), 32'd1);
    step();
    check("jump_c9_req", 32'(mem_req), 32'd1);
    check("jump_c9_addr", 32'(mem_addr), 32'h0200);
    repeat (4) step();
    check("jump_c13_addr", 32'(mem_addr), 32'h0201);
    repeat (3) step();
    check("jump_c16_hold", 32'(hold), 32'd1);
    step();
    check("jump_c17_hold", 32'(hold), 32'd0);
    check("jump_opc", 32'(fetch_opc), 32'hA200);
    check("jump_arg", 32'(fetch_arg), 32'hA201);

    // Wrap-around at pc=0xFFFE
    do_reset(16'hFFFE, 0);
    step();
    check("wrap_addr0", 32'(mem_addr), 32'h7FFF);
    step();
    check("wrap_addr1", 32'(mem_addr), 32'h0000);
    step();
    check("wrap_hold", 32'(hold), 32'd0);
    check("wrap_opc", 32'(fetch_opc), 32'h1FFF); // 0xA000 + 0x7FFF mod 2^16
    check("wrap_arg", 32'(fetch_arg), 32'hA000);

    // Reset mid-request, then a late ack with mem_req=0
    do_reset(16'h0010, 5);
    step();
    step();
    check("rmid_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    pc  = 16'h0000;
    step();
    check("rmid_req", 32'(mem_req), 32'd0);
    check("rmid_hold", 32'(hold), 32'd1);
    rst       = 1'b0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    #1;
    check("late_ack_req", 32'(mem_req), 32'd1);
    check("late_ack_addr", 32'(mem_addr), 32'h0000);
    check("late_ack_hold", 32'(hold), 32'd1);

    // Two wait states, cold fetch at pc=0x20
    do_reset(16'h0020, 2);
    step();
    check("w2_c1_addr", 32'(mem_addr), 32'h0010);
    step();
    check("w2_c2_addr", 32'(mem_addr), 32'h0010);
    step();
    check("w2_c3_addr", 32'(mem_addr), 32'h0010);
    step();
    check("w2_c4_addr", 32'(mem_addr), 32'h0011);
    step();
    check("w2_c5_addr", 32'(mem_addr), 32'h0011);
    step();
    check("w2_c6_hold", 32'(hold), 32'd1);
    step();
    check("w2_c7_hold", 32'(hold), 32'd0);
    check("w2_opc", 32'(fetch_opc), 32'hA010);
    check("w2_arg", 32'(fetch_arg), 32'hA011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
